recovery_arb: RTL and testbench
===============================

Name: recovery_arb

Overview:
Multi-source recovery arbiter and flush sequencer for the out-of-order core. It accepts NUM_CH independent branch/jump mispredict events per cycle and picks the oldest one by ROB age relative to the current ROB head. It issues a one-cycle flush/recover pulse with the redirect PC and rollback tag, then holds a drain window. During that window, younger mispredicts are discarded and an older one preempts with a new pulse. It sits between the branch/ALU resolution ports and the fetch/rename/ROB flush inputs.

Parameters:
NUM_CH, 2, number of mispredict source channels (1..8)
ROB_W, 5, ROB tag width; ROB depth = 2**ROB_W
PC_W, 32, redirect PC width
DRAIN_CYC, 2, post-flush drain window in cycles (0..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
rob_head_i  in  ROB_W  current ROB head tag (oldest in-flight entry)
mp_valid_i  in  NUM_CH  per-channel mispredict event, one-cycle pulse per event
mp_tag_i  in  NUM_CH*ROB_W  per-channel ROB tag of the mispredicting instr, channel c at [c*ROB_W +: ROB_W]
mp_pc_i  in  NUM_CH*PC_W  per-channel correct target PC, channel c at [c*PC_W +: PC_W]
flush_o  out  1  one-cycle flush pulse to frontend/pipeline
flush_pc_o  out  PC_W  redirect PC, valid with flush_o
recover_o  out  1  one-cycle recover pulse to ROB/rename; always equal to flush_o
recover_tag_o  out  ROB_W  tag to roll back to; entries younger than this tag are squashed
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: async on rst high. State=IDLE, drain counter=0, flush_o=0, recover_o=0, flush_pc_o=0, recover_tag_o=0, busy_o=0. Reset during FLUSH or DRAIN aborts immediately; any pending event is lost.
- Age: age(t) = (t - rob_head_i) mod 2**ROB_W, computed as an ROB_W-bit unsigned subtract. A smaller age is older. Wrap-around is handled by the modular subtract.
- Winner: among channels with mp_valid_i=1, the smallest age wins. On equal age, the lowest channel index wins. This is combinational from current inputs.
- States: IDLE, FLUSH, DRAIN. Internal registers: cur_tag (ROB_W), cur_pc (PC_W), drain_cnt (4 bits).
- IDLE: if any valid, capture the winner tag/pc into cur_tag/cur_pc and go to FLUSH. Otherwise stay in IDLE.
- FLUSH (1 cycle): flush_o=recover_o=1, flush_pc_o=cur_pc, recover_tag_o=cur_tag. These are registered outputs, so latency is exactly 1 cycle from the accepting mp_valid_i edge.
  - Older preempt in FLUSH (winner age < age(cur_tag), both ages against the current rob_head_i): capture it and stay in FLUSH, giving a back-to-back second pulse.
  - Otherwise: load drain_cnt=DRAIN_CYC and go to DRAIN. If DRAIN_CYC=0, go directly to IDLE.
- DRAIN: flush_o=recover_o=0.
  - Older preempt: capture it and go to FLUSH.
  - Event with age >= age(cur_tag): dropped silently, since the earlier flush already squashed it.
  - No preempt: decrement drain_cnt; on the cycle drain_cnt==1, go to IDLE.
  - A new event arriving in the same cycle as the DRAIN->IDLE exit is treated as a DRAIN-state event: older preempts, younger is dropped.
- flush_pc_o/recover_tag_o hold their last value outside FLUSH. Consumers sample them only while flush_o=1.
- Sources must pulse mp_valid_i for one cycle per event. A level held into IDLE is taken as a new event.
- No back-pressure: every accepted event produces exactly one pulse. Preempted-but-not-yet-pulsed events never pulse.

Optional Feature:
Macro RECOVERY_ARB_STATS_EN.
- Defined: adds output flush_cnt_o (32 bits, reset 0), which increments once per cycle with flush_o=1 and saturates at all-ones. Also adds output drop_cnt_o (32 bits, reset 0), which increments once per cycle in which at least one valid event is dropped; it also saturates.
- Not defined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
- Reset then single event: NUM_CH=2, head=0, ch0 tag=5 pc=0x100 pulsed at cycle T -> flush_o=recover_o=1 only at T+1 with flush_pc_o=0x100 and recover_tag_o=5; busy_o high T+1..T+3 with DRAIN_CYC=2; IDLE at T+4.
- Simultaneous with wrap: head=30, ch0 tag=2 pc=0x200, ch1 tag=31 pc=0x300 -> one pulse with tag=31, pc=0x300; ch0 is not pulsed.
- Equal-age tie: both channels tag=7 -> channel 0 pc is chosen; exactly one pulse.
- Preempt in DRAIN: after flush of tag=10 (head=0), in the first DRAIN cycle ch1 sends tag=4 pc=0x440 -> second pulse the next cycle with tag=4, pc=0x440, and the drain restarts at DRAIN_CYC.
- Younger dropped: during DRAIN of tag=10, event tag=12 -> no pulse; IDLE on schedule; drop_cnt_o=1 when the macro is defined.
- Reset mid-DRAIN: assert rst asynchronously between clock edges -> busy_o=0 and all outputs 0 immediately; no pulse after rst is released.

Source files
------------

// File: rtl/recovery_arb_if.sv
// recovery_arb_if: bundles the mispredict event inputs and the flush/recover
// outputs of the recovery arbiter. The master side drives events and consumes
// flushes; the slave side is the arbiter itself.
interface recovery_arb_if #(
    parameter int NUM_CH = 2,
    parameter int ROB_W  = 5,
    parameter int PC_W   = 32
);
    logic [ROB_W-1:0]        rob_head_i;
    logic [NUM_CH-1:0]       mp_valid_i;
    logic [NUM_CH*ROB_W-1:0] mp_tag_i;
    logic [NUM_CH*PC_W-1:0]  mp_pc_i;
    logic                    flush_o;
    logic [PC_W-1:0]         flush_pc_o;
    logic                    recover_o;
    logic [ROB_W-1:0]        recover_tag_o;
    logic                    busy_o;

    modport master (
        output rob_head_i, mp_valid_i, mp_tag_i, mp_pc_i,
        input  flush_o, flush_pc_o, recover_o, recover_tag_o, busy_o
    );

    modport slave (
        input  rob_head_i, mp_valid_i, mp_tag_i, mp_pc_i,
        output flush_o, flush_pc_o, recover_o, recover_tag_o, busy_o
    );
endinterface

// File: rtl/recovery_arb.sv
// recovery_arb: picks the oldest mispredict (by ROB age relative to the head)
// among NUM_CH channels, emits a one-cycle flush/recover pulse carrying the
// redirect PC and rollback tag, then holds a drain window during which only
// strictly older mispredicts are accepted (they preempt with a new pulse).
// Optional statistics counters are built when RECOVERY_ARB_STATS_EN is defined.
module recovery_arb #(
    parameter int NUM_CH    = 2,
    parameter int ROB_W     = 5,
    parameter int PC_W      = 32,
    parameter int DRAIN_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    recovery_arb_if.slave        bus
`ifdef RECOVERY_ARB_STATS_EN
    ,
    output logic [31:0]          flush_cnt_o,
    output logic [31:0]          drop_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC);

    // Age of a tag relative to the ROB head; the modular subtract handles wrap.
    function automatic logic [ROB_W-1:0] age_of(input logic [ROB_W-1:0] tag,
                                                 input logic [ROB_W-1:0] head);
        return tag - head;
    endfunction

    state_e            state_q, state_d;
    logic [ROB_W-1:0]  cur_tag_q, cur_tag_d;
    logic [PC_W-1:0]   cur_pc_q, cur_pc_d;
    logic [3:0]        drain_cnt_q, drain_cnt_d;
    logic              flush_q, flush_d;
    logic              busy_q, busy_d;
    logic [PC_W-1:0]   flush_pc_q, flush_pc_d;
    logic [ROB_W-1:0]  recover_tag_q, recover_tag_d;

    logic              win_any;
    logic [ROB_W-1:0]  win_tag;
    logic [PC_W-1:0]   win_pc;
    logic [ROB_W-1:0]  win_age;
    logic [ROB_W-1:0]  ch_age;
    logic [ROB_W-1:0]  cur_age;
    logic              older;

    // Oldest-valid-channel selection; ascending scan with strict compare keeps
    // the lowest channel index on equal age.
    always_comb begin
        win_any = 1'b0;
        win_tag = '0;
        win_pc  = '0;
        win_age = '1;
        ch_age  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.mp_valid_i[c]) begin
                ch_age = age_of(bus.mp_tag_i[c*ROB_W +: ROB_W], bus.rob_head_i);
                if (!win_any || (ch_age < win_age)) begin
                    win_any = 1'b1;
                    win_age = ch_age;
                    win_tag = bus.mp_tag_i[c*ROB_W +: ROB_W];
                    win_pc  = bus.mp_pc_i[c*PC_W +: PC_W];
                end
            end
        end
    end

    // Preempt test: the winner must be strictly older than the tag already
    // flushed, both measured against the current head.
    always_comb begin
        cur_age = age_of(cur_tag_q, bus.rob_head_i);
        older   = win_any && (win_age < cur_age);
    end

    // Next-state and registered-output computation for the flush sequencer.
    always_comb begin
        state_d     = state_q;
        cur_tag_d   = cur_tag_q;
        cur_pc_d    = cur_pc_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_any) begin
                    cur_tag_d = win_tag;
                    cur_pc_d  = win_pc;
                    state_d   = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (older) begin
                    cur_tag_d = win_tag;
                    cur_pc_d  = win_pc;
                    state_d   = S_FLUSH;
                end else begin
                    drain_cnt_d = DRAIN_INIT;
                    state_d     = (DRAIN_CYC == 0) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (older) begin
                    cur_tag_d = win_tag;
                    cur_pc_d  = win_pc;
                    state_d   = S_FLUSH;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                    if (drain_cnt_q == 4'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        flush_d       = (state_d == S_FLUSH);
        busy_d        = (state_d != S_IDLE);
        flush_pc_d    = flush_d ? cur_pc_d  : flush_pc_q;
        recover_tag_d = flush_d ? cur_tag_d : recover_tag_q;
    end

    // Sequencer state and output registers; reset aborts any flush or drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cur_tag_q     <= '0;
            cur_pc_q      <= '0;
            drain_cnt_q   <= '0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            flush_pc_q    <= '0;
            recover_tag_q <= '0;
        end else begin
            state_q       <= state_d;
            cur_tag_q     <= cur_tag_d;
            cur_pc_q      <= cur_pc_d;
            drain_cnt_q   <= drain_cnt_d;
            flush_q       <= flush_d;
            busy_q        <= busy_d;
            flush_pc_q    <= flush_pc_d;
            recover_tag_q <= recover_tag_d;
        end
    end

    assign bus.flush_o       = flush_q;
    assign bus.recover_o     = flush_q;
    assign bus.flush_pc_o    = flush_pc_q;
    assign bus.recover_tag_o = recover_tag_q;
    assign bus.busy_o        = busy_q;

`ifdef RECOVERY_ARB_STATS_EN
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        dropped;

    // An event is dropped when the sequencer is active and nothing older arrived.
    always_comb begin
        dropped     = win_any && (state_q != S_IDLE) && !older;
        flush_cnt_d = flush_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (flush_q && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
        if (dropped && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign flush_cnt_o = flush_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_recovery_arb.sv
// tb_recovery_arb: directed scenarios plus randomized events for recovery_arb,
// checked every cycle against a busy-window reference model.
module tb_recovery_arb;

    localparam int NUM_CH    = 2;
    localparam int ROB_W     = 5;
    localparam int PC_W      = 32;
    localparam int DRAIN_CYC = 2;
    localparam int DEPTH     = 1 << ROB_W;

    logic clk;
    logic rst;

    recovery_arb_if #(.NUM_CH(NUM_CH), .ROB_W(ROB_W), .PC_W(PC_W)) bus ();

`ifdef RECOVERY_ARB_STATS_EN
    logic [31:0] flush_cnt;
    logic [31:0] drop_cnt;
`endif

    recovery_arb #(
        .NUM_CH(NUM_CH), .ROB_W(ROB_W), .PC_W(PC_W), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef RECOVERY_ARB_STATS_EN
        ,
        .flush_cnt_o(flush_cnt),
        .drop_cnt_o(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a pulse flag and the count of busy cycles left.
    bit          m_pulse;
    int          m_busy_left;
    int          m_tag;
    logic [31:0] m_pc;
    int          m_flushes;
    int          m_drops;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int age(input int t, input int h);
        return (t - h + DEPTH) % DEPTH;
    endfunction

    task automatic model_reset();
        m_pulse     = 1'b0;
        m_busy_left = 0;
        m_tag       = 0;
        m_pc        = '0;
        m_flushes   = 0;
        m_drops     = 0;
    endtask

    // Advance the model by one clock edge given the inputs driven this cycle.
    task automatic model_edge(input logic [1:0] v, input int t0, input int t1,
                              input logic [31:0] p0, input logic [31:0] p1, input int head);
        int          key, best, wage, wtag;
        logic [31:0] wpc;
        if (m_pulse) m_flushes++;   // stats count the pulse that is ending now
        best = -1;
        wtag = 0;
        wpc  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (v[c]) begin
                key = age((c == 0) ? t0 : t1, head) * NUM_CH + c;
                if (best < 0 || key < best) begin
                    best = key;
                    wtag = (c == 0) ? t0 : t1;
                    wpc  = (c == 0) ? p0 : p1;
                end
            end
        end
        if (best < 0) begin
            m_pulse = 1'b0;
            if (m_busy_left > 0) m_busy_left--;
        end else begin
            wage = best / NUM_CH;
            if (m_busy_left == 0 || wage < age(m_tag, head)) begin
                m_pulse     = 1'b1;
                m_tag       = wtag;
                m_pc        = wpc;
                m_busy_left = 1 + DRAIN_CYC;
            end else begin
                m_pulse = 1'b0;
                m_drops++;
                m_busy_left--;
            end
        end
    endtask

    task automatic check_model();
        chk("flush_o", 64'(bus.flush_o), 64'(m_pulse));
        chk("recover_o", 64'(bus.recover_o), 64'(m_pulse));
        chk("busy_o", 64'(bus.busy_o), 64'(m_busy_left > 0));
        chk("flush_pc_o", 64'(bus.flush_pc_o), 64'(m_pc));
        chk("recover_tag_o", 64'(bus.recover_tag_o), 64'(m_tag));
`ifdef RECOVERY_ARB_STATS_EN
        chk("flush_cnt_o", 64'(flush_cnt), 64'(m_flushes));
        chk("drop_cnt_o", 64'(drop_cnt), 64'(m_drops));
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, then check after the next.
    task automatic step(input logic [1:0] v, input logic [4:0] t0, input logic [4:0] t1,
                        input logic [31:0] p0, input logic [31:0] p1, input logic [4:0] head);
        bus.mp_valid_i = v;
        bus.mp_tag_i   = {t1, t0};
        bus.mp_pc_i    = {p1, p0};
        bus.rob_head_i = head;
        model_edge(v, int'(t0), int'(t1), p0, p1, int'(head));
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input logic [4:0] head);
        step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, head);
    endtask

    initial begin
        rst            = 1'b1;
        bus.mp_valid_i = '0;
        bus.mp_tag_i   = '0;
        bus.mp_pc_i    = '0;
        bus.rob_head_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_flush", 64'(bus.flush_o), 64'd0);
        chk("reset_busy", 64'(bus.busy_o), 64'd0);
        chk("reset_pc", 64'(bus.flush_pc_o), 64'd0);
        chk("reset_tag", 64'(bus.recover_tag_o), 64'd0);
        rst = 1'b0;

        // Single event: pulse at T+1, busy T+1..T+3, idle at T+4.
        step(2'b01, 5'd5, 5'd0, 32'h100, 32'h0, 5'd0);
        chk("single_flush", 64'(bus.flush_o), 64'd1);
        chk("single_pc", 64'(bus.flush_pc_o), 64'h100);
        chk("single_tag", 64'(bus.recover_tag_o), 64'd5);
        idle(5'd0);
        chk("single_drain1_busy", 64'(bus.busy_o), 64'd1);
        chk("single_drain1_flush", 64'(bus.flush_o), 64'd0);
        idle(5'd0);
        chk("single_drain2_busy", 64'(bus.busy_o), 64'd1);
        idle(5'd0);
        chk("single_idle_busy", 64'(bus.busy_o), 64'd0);

        // Simultaneous events across the wrap point: tag 31 is older than 2 at head 30.
        step(2'b11, 5'd2, 5'd31, 32'h200, 32'h300, 5'd30);
        chk("wrap_tag", 64'(bus.recover_tag_o), 64'd31);
        chk("wrap_pc", 64'(bus.flush_pc_o), 64'h300);
        repeat (3) idle(5'd30);

        // Equal age: channel 0 wins.
        step(2'b11, 5'd7, 5'd7, 32'hA0, 32'hB0, 5'd0);
        chk("tie_pc", 64'(bus.flush_pc_o), 64'hA0);
        repeat (3) idle(5'd0);

        // Older event in the first drain cycle preempts and restarts the drain.
        step(2'b01, 5'd10, 5'd0, 32'h1000, 32'h0, 5'd0);
        idle(5'd0);
        step(2'b10, 5'd0, 5'd4, 32'h0, 32'h440, 5'd0);
        chk("preempt_flush", 64'(bus.flush_o), 64'd1);
        chk("preempt_tag", 64'(bus.recover_tag_o), 64'd4);
        chk("preempt_pc", 64'(bus.flush_pc_o), 64'h440);
        idle(5'd0);
        idle(5'd0);
        chk("preempt_restart_busy", 64'(bus.busy_o), 64'd1);
        idle(5'd0);
        chk("preempt_end_busy", 64'(bus.busy_o), 64'd0);

        // Younger event during drain is dropped; drain ends on schedule.
        step(2'b01, 5'd10, 5'd0, 32'h1000, 32'h0, 5'd0);
        idle(5'd0);
        step(2'b01, 5'd12, 5'd0, 32'h1200, 32'h0, 5'd0);
        chk("drop_no_flush", 64'(bus.flush_o), 64'd0);
        chk("drop_tag_held", 64'(bus.recover_tag_o), 64'd10);
        idle(5'd0);
        chk("drop_idle_busy", 64'(bus.busy_o), 64'd0);

        // Asynchronous reset in the middle of the drain window.
        step(2'b01, 5'd9, 5'd0, 32'h900, 32'h0, 5'd0);
        idle(5'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy_o), 64'd0);
        chk("arst_flush", 64'(bus.flush_o), 64'd0);
        chk("arst_recover", 64'(bus.recover_o), 64'd0);
        chk("arst_pc", 64'(bus.flush_pc_o), 64'd0);
        chk("arst_tag", 64'(bus.recover_tag_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) idle(5'd0);

        // Randomized events against the model.
        for (int i = 0; i < 600; i++) begin
            logic [1:0]  v;
            logic [4:0]  t0, t1, head;
            logic [31:0] p0, p1;
            v[0] = ($urandom_range(0, 99) < 30);
            v[1] = ($urandom_range(0, 99) < 30);
            head = 5'($urandom_range(0, DEPTH - 1));
            t0   = 5'($urandom_range(0, DEPTH - 1));
            t1   = ($urandom_range(0, 3) == 0) ? t0 : 5'($urandom_range(0, DEPTH - 1));
            p0   = $urandom;
            p1   = $urandom;
            step(v, t0, t1, p0, p1, head);
        end
        repeat (4) idle(5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
